// File: rtl/tpsram_fifo_pkg.sv
// Shared defaults and width helpers for the tpsram_fifo block.
package tpsram_fifo_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 9;
  localparam int AFULL_THR_DEF  = 480;
  localparam int AEMPTY_THR_DEF = 32;

  // COUNT needs one extra bit so that a completely full FIFO (DEPTH) is representable.
  function automatic int count_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/tpsram_fifo_mem.sv
// Simple dual-port storage for tpsram_fifo: synchronous write, synchronous read
// followed by an output register that only loads when a read word arrives.
module tpsram_fifo_mem #(
  parameter int WIDTH  = 33,
  parameter int ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic              oce_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] ram_q;
  logic [WIDTH-1:0] rdata_q;

  // Array write port; contents are intentionally never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Synchronous read stage of the RAM macro.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      ram_q <= mem_q[raddr_i];
    end
  end

  // Output register holds the last delivered word between reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= {WIDTH{1'b0}};
    end else if (oce_i) begin
      rdata_q <= ram_q;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tpsram_fifo.sv
// Single-clock FIFO on a two-port RAM with occupancy flags and sticky errors.
// Define TPSRAM_FIFO_PARITY_EN to store an even-parity bit per word and drive PERR.
module tpsram_fifo
  import tpsram_fifo_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int AFULL_THR  = AFULL_THR_DEF,
  parameter int AEMPTY_THR = AEMPTY_THR_DEF
) (
  input  logic                        CLK,
  input  logic                        RESETN,
  input  logic [DATA_W-1:0]           WD,
  input  logic                        WE,
  input  logic                        RE,
  output logic [DATA_W-1:0]           RD,
  output logic                        RVALID,
  output logic                        FULL,
  output logic                        AFULL,
  output logic                        EMPTY,
  output logic                        AEMPTY,
  output logic [count_w(ADDR_W)-1:0]  COUNT,
  output logic                        OVF,
  output logic                        UDF,
  output logic                        PERR
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = count_w(ADDR_W);
`ifdef TPSRAM_FIFO_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [CW-1:0]     CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0]     CNT_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0]     CNT_AF    = CW'(AFULL_THR);
  localparam logic [CW-1:0]     CNT_AE    = CW'(AEMPTY_THR);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1'b1);

  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d, afull_q, afull_d;
  logic              empty_q, empty_d, aempty_q, aempty_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              rd_pend_q, rd_pend_d, rvalid_q, rvalid_d;
  logic              wr_acc, rd_acc;
  logic [MEM_W-1:0]  mem_wdata, mem_rdata;

  // Acceptance uses registered flags only, so a full FIFO never writes through a read.
  assign wr_acc = WE & ~full_q;
  assign rd_acc = RE & ~empty_q;

  // Next-state for pointers, occupancy, flags, errors and the read-valid pipeline.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    if (wr_acc) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (rd_acc) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d    = (count_d == CNT_DEPTH);
    empty_d   = (count_d == {CW{1'b0}});
    afull_d   = (count_d >= CNT_AF);
    aempty_d  = (count_d <= CNT_AE);
    ovf_d     = ovf_q | (WE & full_q);
    udf_d     = udf_q | (RE & empty_q);
    rd_pend_d = rd_acc;
    rvalid_d  = rd_pend_q;
  end

  // State registers; clearing rd_pend_q/rvalid_q discards any read in flight.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wptr_q    <= {ADDR_W{1'b0}};
      rptr_q    <= {ADDR_W{1'b0}};
      count_q   <= {CW{1'b0}};
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      empty_q   <= 1'b1;
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      empty_q   <= empty_d;
      aempty_q  <= aempty_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      rd_pend_q <= rd_pend_d;
      rvalid_q  <= rvalid_d;
    end
  end

`ifdef TPSRAM_FIFO_PARITY_EN
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  assign mem_wdata = {even_parity(WD), WD};
  assign RD        = mem_rdata[DATA_W-1:0];
  assign PERR      = rvalid_q & (mem_rdata[DATA_W] != even_parity(mem_rdata[DATA_W-1:0]));
`else
  assign mem_wdata = WD;
  assign RD        = mem_rdata;
  assign PERR      = 1'b0;
`endif

  tpsram_fifo_mem #(
    .WIDTH  (MEM_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (CLK),
    .rst_ni  (RESETN),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (mem_wdata),
    .re_i    (rd_acc),
    .raddr_i (rptr_q),
    .oce_i   (rd_pend_q),
    .rdata_o (mem_rdata)
  );

  assign RVALID = rvalid_q;
  assign FULL   = full_q;
  assign AFULL  = afull_q;
  assign EMPTY  = empty_q;
  assign AEMPTY = aempty_q;
  assign COUNT  = count_q;
  assign OVF    = ovf_q;
  assign UDF    = udf_q;

endmodule

// File: tb/tb_tpsram_fifo.sv
// Directed self-checking bench for tpsram_fifo (default 32x512 configuration).
module tb_tpsram_fifo;

  logic        CLK, RESETN, WE, RE;
  logic [31:0] WD, RD;
  logic        RVALID, FULL, AFULL, EMPTY, AEMPTY, OVF, UDF, PERR;
  logic [9:0]  COUNT;

  int n_cmp = 0;
  int n_err = 0;

  tpsram_fifo dut (
    .CLK(CLK), .RESETN(RESETN), .WD(WD), .WE(WE), .RE(RE), .RD(RD), .RVALID(RVALID),
    .FULL(FULL), .AFULL(AFULL), .EMPTY(EMPTY), .AEMPTY(AEMPTY), .COUNT(COUNT),
    .OVF(OVF), .UDF(UDF), .PERR(PERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic step(input logic we, input logic re, input logic [31:0] wd);
    WE = we;
    RE = re;
    WD = wd;
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] fifo_m[$];
  logic [31:0] exp_rd[$];
  logic        prev_rd, do_we, do_re;
  logic [31:0] wd_r;
  int          wr_n;

  initial begin
    RESETN = 1'b0; WE = 1'b0; RE = 1'b0; WD = 32'h0;
    #12;
    chk_w("rst_count", 32'(COUNT), 32'd0);
    chk_b("rst_empty", EMPTY, 1'b1);
    chk_b("rst_aempty", AEMPTY, 1'b1);
    chk_b("rst_full", FULL, 1'b0);
    chk_b("rst_afull", AFULL, 1'b0);
    chk_b("rst_rvalid", RVALID, 1'b0);
    chk_w("rst_rd", RD, 32'h0);
    chk_b("rst_ovf", OVF, 1'b0);
    chk_b("rst_udf", UDF, 1'b0);
    chk_b("rst_perr", PERR, 1'b0);
    RESETN = 1'b1;

    // Three writes then three reads; data lags RE by one extra edge.
    step(1'b1, 1'b0, 32'h1);
    chk_w("first_edge_count", 32'(COUNT), 32'd1);
    step(1'b1, 1'b0, 32'h2);
    step(1'b1, 1'b0, 32'h3);
    chk_w("w3_count", 32'(COUNT), 32'd3);
    chk_b("w3_empty", EMPTY, 1'b0);
    step(1'b0, 1'b1, 32'h0);
    chk_b("r1_rvalid_lat", RVALID, 1'b0);
    chk_w("r1_count", 32'(COUNT), 32'd2);
    step(1'b0, 1'b1, 32'h0);
    chk_b("r2_rvalid", RVALID, 1'b1);
    chk_w("r2_rd", RD, 32'h1);
    step(1'b0, 1'b1, 32'h0);
    chk_w("r3_rd", RD, 32'h2);
    chk_w("r3_count", 32'(COUNT), 32'd0);
    chk_b("r3_empty", EMPTY, 1'b1);
    step(1'b0, 1'b0, 32'h0);
    chk_b("r4_rvalid", RVALID, 1'b1);
    chk_w("r4_rd", RD, 32'h3);
    step(1'b0, 1'b0, 32'h0);
    chk_b("idle_rvalid", RVALID, 1'b0);
    chk_w("idle_rd_hold", RD, 32'h3);

    // Fill to full, checking threshold boundaries.
    for (int k = 1; k <= 512; k++) begin
      step(1'b1, 1'b0, 32'h100 + 32'(k - 1));
      if (k == 32 || k == 33 || k == 479 || k == 480 || k == 511 || k == 512) begin
        chk_w("fill_count", 32'(COUNT), 32'(k));
        chk_b("fill_aempty", AEMPTY, k <= 32);
        chk_b("fill_afull", AFULL, k >= 480);
        chk_b("fill_full", FULL, k == 512);
      end
    end
    chk_b("full_ovf_clear", OVF, 1'b0);
    step(1'b1, 1'b0, 32'hDEAD);
    chk_b("ovf_set", OVF, 1'b1);
    chk_w("ovf_count", 32'(COUNT), 32'd512);

    // Full with WE and RE together: read only.
    step(1'b1, 1'b1, 32'hBEEF);
    chk_w("fullrw_count", 32'(COUNT), 32'd511);
    chk_b("fullrw_full", FULL, 1'b0);
    chk_b("fullrw_afull", AFULL, 1'b1);
    chk_b("fullrw_ovf", OVF, 1'b1);
    for (int j = 0; j <= 510; j++) begin
      step(1'b0, 1'b1, 32'h0);
      chk_b("drain_rvalid", RVALID, 1'b1);
      chk_w("drain_rd", RD, 32'h100 + 32'(j));
    end
    chk_w("drain_count", 32'(COUNT), 32'd0);
    chk_b("drain_empty", EMPTY, 1'b1);
    step(1'b0, 1'b0, 32'h0);
    chk_w("drain_last", RD, 32'h2FF);
    chk_b("drain_perr", PERR, 1'b0);
    chk_b("drain_udf", UDF, 1'b0);

    // Empty with WE and RE together: write only.
    step(1'b1, 1'b1, 32'h55);
    chk_w("emptyrw_count", 32'(COUNT), 32'd1);
    chk_b("emptyrw_udf", UDF, 1'b1);
    chk_b("emptyrw_empty", EMPTY, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk_b("emptyrw_rvalid", RVALID, 1'b0);
    step(1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk_b("emptyrw_rd_valid", RVALID, 1'b1);
    chk_w("emptyrw_rd", RD, 32'h55);

    // Reset pulse with a read in flight.
    step(1'b1, 1'b0, 32'h11);
    step(1'b1, 1'b0, 32'h22);
    step(1'b0, 1'b1, 32'h0);
    RESETN = 1'b0;
    #2;
    chk_b("midrst_rvalid", RVALID, 1'b0);
    chk_w("midrst_count", 32'(COUNT), 32'd0);
    chk_b("midrst_empty", EMPTY, 1'b1);
    chk_b("midrst_udf", UDF, 1'b0);
    chk_b("midrst_ovf", OVF, 1'b0);
    RESETN = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    chk_b("postrst_rvalid", RVALID, 1'b0);
    chk_w("postrst_rd", RD, 32'h0);
    step(1'b1, 1'b0, 32'h33);
    chk_w("postrst_count", 32'(COUNT), 32'd1);
    fifo_m.push_back(32'h33);

    // Random concurrent stream of 1500 words across pointer wraps.
    prev_rd = 1'b0;
    wr_n = 0;
    for (int cyc = 0; cyc < 20000 && (wr_n < 1500 || fifo_m.size() > 0 || exp_rd.size() > 0); cyc++) begin
      do_we = (wr_n < 1500) && (fifo_m.size() < 512) && ($urandom_range(0, 99) < 55);
      do_re = (fifo_m.size() > 0) && (($urandom_range(0, 99) < 50) || (wr_n >= 1500));
      wd_r  = $urandom;
      step(do_we, do_re, wd_r);
      if (do_re) exp_rd.push_back(fifo_m.pop_front());
      if (do_we) begin
        fifo_m.push_back(wd_r);
        wr_n++;
      end
      chk_w("stream_count", 32'(COUNT), 32'(fifo_m.size()));
      chk_b("stream_rvalid", RVALID, prev_rd);
      if (prev_rd) chk_w("stream_rd", RD, exp_rd.pop_front());
      prev_rd = do_re;
    end
    chk_b("stream_done", (wr_n == 1500) && (exp_rd.size() == 0) && (fifo_m.size() == 0), 1'b1);
    chk_b("stream_ovf", OVF, 1'b0);
    chk_b("stream_udf", UDF, 1'b0);
    chk_b("stream_empty", EMPTY, 1'b1);

`ifdef TPSRAM_FIFO_PARITY_EN
    step(1'b1, 1'b0, 32'hA5A50001);
    dut.u_mem.mem_q[dut.wptr_q - 9'd1][32] = ~dut.u_mem.mem_q[dut.wptr_q - 9'd1][32];
    step(1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk_b("par_rvalid", RVALID, 1'b1);
    chk_w("par_rd", RD, 32'hA5A50001);
    chk_b("par_perr", PERR, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tpsram_fifo.md
TPSRAM_FIFO -- requirements
Module: tpsram_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, stored word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 9, address width; depth DEPTH = 2**ADDR_W (512).
REQ-003 SHALL have parameter AFULL_THR, default 480, almost-full threshold in words.
REQ-004 SHALL have parameter AEMPTY_THR, default 32, almost-empty threshold in words.
REQ-005 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port RESETN  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port WD  input  DATA_W  write data.
REQ-008 SHALL have port WE  input  1  write request.
REQ-009 SHALL have port RE  input  1  read request.
REQ-010 SHALL have port RD  output  DATA_W  read data, valid when RVALID=1.
REQ-011 SHALL have port RVALID  output  1  RD holds a newly read word this cycle.
REQ-012 SHALL have ports FULL, AFULL, EMPTY, AEMPTY  output  1 each  occupancy flags.
REQ-013 SHALL have port COUNT  output  ADDR_W+1  stored word count, 0..DEPTH.
REQ-014 SHALL have ports OVF, UDF  output  1 each  sticky overflow / underflow error.
REQ-015 SHALL have port PERR  output  1  parity error on the current RD word (see Configuration).

Function
REQ-016 Write SHALL be accepted iff WE=1 and FULL=0; WD stored at write pointer, pointer +1 mod DEPTH.
REQ-017 Read SHALL be accepted iff RE=1 and EMPTY=0; read pointer +1 mod DEPTH.
REQ-018 Read latency SHALL be 1 cycle: word of a read accepted at edge N appears on RD with RVALID=1 after edge N+1, held for one cycle.
REQ-019 RD SHALL hold its last value when RVALID=0.
REQ-020 COUNT SHALL be +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write.
REQ-021 FULL=(COUNT==DEPTH), EMPTY=(COUNT==0), AFULL=(COUNT>=AFULL_THR), AEMPTY=(COUNT<=AEMPTY_THR); all registered, consistent with COUNT every cycle.
REQ-022 WE=1 while FULL=1 SHALL drop the write and set OVF, even if a read is accepted same cycle (no write-through).
REQ-023 RE=1 while EMPTY=1 SHALL be ignored and set UDF, even if a write is accepted same cycle (no read-through).
REQ-024 OVF and UDF SHALL stay set until reset.
REQ-025 Pointers SHALL wrap from DEPTH-1 to 0 without bubble; order SHALL be strictly first-in first-out.

Reset
REQ-026 RESETN low SHALL asynchronously clear pointers, COUNT, RD, RVALID, FULL, AFULL, OVF, UDF, PERR to 0 and set EMPTY, AEMPTY to 1.
REQ-027 Memory contents SHALL NOT be reset; reset mid-operation SHALL discard an in-flight read (RVALID=0 after release).
REQ-028 First accepted operation SHALL be possible on the first rising edge after RESETN deasserts.

Configuration
REQ-029 With TPSRAM_FIFO_PARITY_EN defined, memory SHALL be DATA_W+1 wide storing even parity of WD; PERR SHALL be 1 with RVALID when stored parity mismatches RD.
REQ-030 Without TPSRAM_FIFO_PARITY_EN, memory SHALL be DATA_W wide and PERR SHALL be constant 0.

Structure
REQ-031 Package tpsram_fifo_pkg SHALL hold default width/depth/threshold constants and the COUNT width function.
REQ-032 Storage SHALL be a sub-module tpsram_fifo_mem: simple dual-port, synchronous write, synchronous registered read, inferable to one or more RAM1K18 blocks.
REQ-033 Pointer, count, flag and error logic SHALL reside in tpsram_fifo itself.

Verification
REQ-034 Reset release, write 0x00000001..0x00000003, read 3 -> RD 1,2,3 each one cycle after RE, COUNT 3->0, EMPTY=1.
REQ-035 Write 512 words -> FULL=1 at COUNT=512, AFULL=1 from COUNT=480; 513th WE -> OVF=1, COUNT stays 512.
REQ-036 FULL with simultaneous WE and RE -> read accepted, write dropped, OVF=1, COUNT=511.
REQ-037 EMPTY with simultaneous WE and RE -> write accepted, UDF=1, COUNT=1, RVALID=0 next cycle.
REQ-038 Stream 1500 words with concurrent random WE/RE -> output equals input order across pointer wrap, no OVF/UDF.
REQ-039 RESETN pulse one cycle after accepted read -> RVALID=0, COUNT=0, EMPTY=1; with TPSRAM_FIFO_PARITY_EN, forced stored-parity flip -> PERR=1 with that word.
